// File: rtl/si_tag_serializer.sv
// si_tag_serializer: drains one parallel tag bundle (lane-masked by tkeep) as a
// stream of single tags, lowest lane first, and forwards a monotonic lower
// bound on the time of every tag not yet issued.
// Optional feature macro: SI_TAG_SERIALIZER_CHANNEL_FILTER_EN adds the
// channel_mask port and drops lanes whose channel is not enabled.
module si_tag_serializer #(
   parameter int NUMBER_OF_WORDS = 4,
   parameter int CHANNEL_COUNT   = 20
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             s_axis_tvalid,
   output logic                             s_axis_tready,
   input  logic [NUMBER_OF_WORDS-1:0][63:0] s_axis_tagtime,
   input  logic [NUMBER_OF_WORDS-1:0][5:0]  s_axis_channel,
   input  logic [NUMBER_OF_WORDS-1:0]       s_axis_tkeep,
   input  logic [63:0]                      s_lowest_time_bound,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic [63:0]                      m_axis_tagtime,
   output logic signed [5:0]                m_axis_channel,
   output logic                             m_axis_tlast,
   output logic [63:0]                      lowest_time_bound
`ifdef SI_TAG_SERIALIZER_CHANNEL_FILTER_EN
   ,
   input  logic [2*CHANNEL_COUNT-1:0]       channel_mask
`endif
);

   localparam int N  = NUMBER_OF_WORDS;
   localparam int LW = (N > 1) ? $clog2(N) : 1;

   // IDLE/DRAIN is fully determined by the pending lane mask
   typedef enum logic {IDLE, DRAIN} state_t;

   state_t                state;
   logic [N-1:0]          pending;
   logic [N-1:0][63:0]    tag_q;
   logic [N-1:0][5:0]     ch_q;
   logic [N-1:0]          kept;
   logic [N-1:0]          lane_oh;
   logic [LW-1:0]         lane;
   logic                  single;
   logic                  issue;
   logic                  accept;

   assign state  = (pending == '0) ? IDLE : DRAIN;
   assign single = (pending != '0) && ((pending & (pending - N'(1))) == '0);
   assign issue  = (state == DRAIN) && (!m_axis_tvalid || m_axis_tready);
   // Ready in the same cycle the last pending lane leaves, so one-lane bundles stream at 1/clk
   assign s_axis_tready = rst && ((state == IDLE) || (issue && single));
   assign accept = s_axis_tvalid && s_axis_tready;

   // Lanes that will actually be issued from the incoming bundle
   always_comb begin
      kept = s_axis_tkeep;
`ifdef SI_TAG_SERIALIZER_CHANNEL_FILTER_EN
      for (int i = 0; i < N; i++) begin
         int  ch_i;
         int  idx;
         logic sel;
         ch_i = int'(signed'(s_axis_channel[i]));
         idx  = -1;
         sel  = 1'b0;
         if (ch_i > 0)
            idx = ch_i - 1;
         else if (ch_i < 0)
            idx = CHANNEL_COUNT - 1 - ch_i;
         for (int j = 0; j < 2*CHANNEL_COUNT; j++)
            if (j == idx) sel = channel_mask[j];
         kept[i] = s_axis_tkeep[i] && sel;
      end
`endif
   end

   // Lowest pending lane is the next one to go out
   always_comb begin
      lane    = '0;
      lane_oh = '0;
      for (int i = N-1; i >= 0; i--) begin
         if (pending[i]) begin
            lane    = LW'(i);
            lane_oh = N'(1) << i;
         end
      end
   end

   // Bundle capture, tag issue, output register hold and bound tracking
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending           <= '0;
         tag_q             <= '0;
         ch_q              <= '0;
         m_axis_tvalid     <= 1'b0;
         m_axis_tagtime    <= '0;
         m_axis_channel    <= '0;
         m_axis_tlast      <= 1'b0;
         lowest_time_bound <= '0;
      end else begin
         if (issue) begin
            m_axis_tvalid  <= 1'b1;
            m_axis_tagtime <= tag_q[lane];
            m_axis_channel <= signed'(ch_q[lane]);
            m_axis_tlast   <= single;
            pending        <= pending & ~lane_oh;
         end else if (m_axis_tready) begin
            m_axis_tvalid  <= 1'b0;
         end
         // Accept only happens when pending empties this cycle, so it overrides the clear
         if (accept) begin
            pending <= kept;
            tag_q   <= s_axis_tagtime;
            ch_q    <= s_axis_channel;
         end
         // The bound may only rise; converter bound is trusted only with nothing queued
         if (issue) begin
            if (tag_q[lane] > lowest_time_bound)
               lowest_time_bound <= tag_q[lane];
         end else if ((state == IDLE) && !accept) begin
            if (s_lowest_time_bound > lowest_time_bound)
               lowest_time_bound <= s_lowest_time_bound;
         end
      end
   end

endmodule

// File: tb/tb_si_tag_serializer.sv
// Bench for si_tag_serializer: queue-based reference model, per-cycle compare,
// directed literal checks and a randomized stream phase.
module tb_si_tag_serializer;
   localparam int N  = 4;
   localparam int CC = 20;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                s_tvalid = 1'b0;
   logic                s_tready;
   logic [N-1:0][63:0]  s_tagtime = '0;
   logic [N-1:0][5:0]   s_channel = '0;
   logic [N-1:0]        s_tkeep = '0;
   logic [63:0]         s_lowb = '0;
   logic                m_tvalid;
   logic                m_tready = 1'b1;
   logic [63:0]         m_tagtime;
   logic signed [5:0]   m_channel;
   logic                m_tlast;
   logic [63:0]         bound;
`ifdef SI_TAG_SERIALIZER_CHANNEL_FILTER_EN
   logic [2*CC-1:0]     channel_mask = '1;
`endif

   always #5 clk = ~clk;

   si_tag_serializer #(.NUMBER_OF_WORDS(N), .CHANNEL_COUNT(CC)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .s_axis_tagtime(s_tagtime), .s_axis_channel(s_channel),
      .s_axis_tkeep(s_tkeep), .s_lowest_time_bound(s_lowb),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tagtime(m_tagtime), .m_axis_channel(m_channel),
      .m_axis_tlast(m_tlast), .lowest_time_bound(bound)
`ifdef SI_TAG_SERIALIZER_CHANNEL_FILTER_EN
      , .channel_mask(channel_mask)
`endif
   );

   typedef struct {
      logic [63:0] t;
      logic [5:0]  ch;
      logic        last;
   } tag_t;

   tag_t        q[$];      // tags accepted but not yet loaded into the output slot
   tag_t        seen[$];   // tags observed leaving through the handshake
   tag_t        slot;
   bit          slot_v = 0;
   logic [63:0] mbound = '0;
   int          acc_cnt = 0;
   int          tests = 0;
   int          fails = 0;
   bit          rnd_en = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic bit lane_allowed(input logic [5:0] ch);
`ifdef SI_TAG_SERIALIZER_CHANNEL_FILTER_EN
      int              c;
      logic [2*CC-1:0] sh;
      c = int'(signed'(ch));
      if (c == 0) return 1'b0;
      sh = channel_mask >> ((c > 0) ? (c - 1) : (CC - 1 - c));
      return sh[0];
`else
      return (ch == ch) ? 1'b1 : 1'b1;
`endif
   endfunction

   function automatic bit exp_tready();
      return rst && (q.size() == 0 || (q.size() == 1 && (!slot_v || m_tready)));
   endfunction

   // Reference model: what the serializer must hold after each edge
   initial forever begin : model
      bit ci, tr, acc, idle;
      int last_i;
      @(posedge clk or negedge rst);
      if (!rst) begin
         q.delete();
         slot_v = 0;
         mbound = '0;
      end else begin
         ci   = (q.size() > 0) && (!slot_v || m_tready);
         tr   = (q.size() == 0) || (ci && q.size() == 1);
         acc  = s_tvalid && tr;
         idle = (q.size() == 0);
         if (ci) begin
            slot   = q.pop_front();
            slot_v = 1;
            if (slot.t > mbound) mbound = slot.t;
         end else begin
            if (m_tready) slot_v = 0;
            if (idle && !acc && s_lowb > mbound) mbound = s_lowb;
         end
         if (acc) begin
            acc_cnt++;
            last_i = -1;
            for (int i = 0; i < N; i++)
               if (s_tkeep[i] && lane_allowed(s_channel[i])) last_i = i;
            for (int i = 0; i < N; i++)
               if (s_tkeep[i] && lane_allowed(s_channel[i]))
                  q.push_back('{t: s_tagtime[i], ch: s_channel[i], last: (i == last_i)});
         end
      end
   end

   // Compare process, mid-cycle
   initial forever begin : compare
      @(negedge clk);
      if (!rst) begin
         chk("rst_tvalid", m_tvalid, 0);
         chk("rst_s_tready", s_tready, 0);
         chk("rst_bound", bound, 0);
      end else begin
         chk("s_tready", s_tready, exp_tready());
         chk("m_tvalid", m_tvalid, slot_v);
         if (slot_v && m_tvalid) begin
            chk("m_tagtime", m_tagtime, slot.t);
            chk("m_channel", 64'(m_channel[5:0]), 64'(slot.ch));
            chk("m_tlast", m_tlast, slot.last);
         end
         chk("bound", bound, mbound);
         if (m_tvalid && m_tready)
            seen.push_back('{t: m_tagtime, ch: m_channel, last: m_tlast});
      end
   end

   // Random sink back-pressure
   initial forever begin : sink
      @(posedge clk);
      #1;
      if (rnd_en) m_tready = ($urandom_range(0, 3) != 0);
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      s_tvalid = 1'b0;
      s_tkeep = '0;
      s_lowb = '0;
`ifdef SI_TAG_SERIALIZER_CHANNEL_FILTER_EN
      channel_mask = '1;
`endif
      tick(2);
      rst = 1'b1;
      seen.delete();
   endtask

   // Present one bundle and hold it until accepted (bounded)
   task automatic send(input logic [N-1:0] keep, input logic [N-1:0][63:0] t,
                       input logic [N-1:0][5:0] ch, input logic [63:0] lowb);
      int start;
      start = acc_cnt;
      s_tvalid = 1'b1;
      s_tkeep = keep;
      s_tagtime = t;
      s_channel = ch;
      s_lowb = lowb;
      for (int c = 0; c < 50 && acc_cnt == start; c++) tick(1);
      chk("accept_in_time", acc_cnt != start, 1);
      s_tvalid = 1'b0;
   endtask

   logic [N-1:0][63:0] tt;
   logic [N-1:0][5:0]  cc;
   logic [63:0]        base;

   initial begin
      tick(1);
      chk("reset_tvalid", m_tvalid, 0);
      chk("reset_bound", bound, 0);

      // single-lane bundle
      do_reset();
      m_tready = 1'b1;
      tt = '0; cc = '0; tt[0] = 64'd1000; cc[0] = 6'd3;
      send(4'b0001, tt, cc, 64'd0);
      chk("t1_not_yet", m_tvalid, 0);
      tick(1);
      chk("t1_tvalid", m_tvalid, 1);
      chk("t1_time", m_tagtime, 1000);
      chk("t1_ch", 64'(m_channel[5:0]), 3);
      chk("t1_tlast", m_tlast, 1);
      chk("t1_bound", bound, 1000);

      // three kept lanes of four
      do_reset();
      tt = '0; cc = '0; tt[0] = 10; tt[1] = 20; tt[3] = 40;
      cc[0] = 1; cc[1] = 2; cc[3] = 4;
      send(4'b1011, tt, cc, 64'd0);
      chk("t2_sready0", s_tready, 0);
      tick(1);
      chk("t2_time0", m_tagtime, 10);
      chk("t2_last0", m_tlast, 0);
      chk("t2_sready1", s_tready, 0);
      tick(1);
      chk("t2_time1", m_tagtime, 20);
      chk("t2_sready2", s_tready, 1);
      tick(1);
      chk("t2_time2", m_tagtime, 40);
      chk("t2_last2", m_tlast, 1);
      chk("t2_bound", bound, 40);

      // stall after the first tag
      do_reset();
      send(4'b1011, tt, cc, 64'd0);
      tick(1);
      m_tready = 1'b0;
      tick(5);
      chk("t3_hold_valid", m_tvalid, 1);
      chk("t3_hold_time", m_tagtime, 10);
      m_tready = 1'b1;
      tick(6);
      chk("t3_count", seen.size(), 3);
      if (seen.size() == 3) begin
         chk("t3_seq0", seen[0].t, 10);
         chk("t3_seq1", seen[1].t, 20);
         chk("t3_seq2", seen[2].t, 40);
         chk("t3_last", seen[2].last, 1);
      end

      // empty bundle, bound forwarding
      do_reset();
      send(4'b0000, tt, cc, 64'd5000);
      chk("t4_bound_hold", bound, 0);
      tick(1);
      chk("t4_bound", bound, 5000);
      s_lowb = 64'd100;
      tick(3);
      chk("t4_bound_mono", bound, 5000);
      chk("t4_no_tag", m_tvalid, 0);

      // asynchronous reset mid-drain
      do_reset();
      m_tready = 1'b0;
      tt = '0; tt[0] = 1; tt[1] = 2; tt[2] = 3; tt[3] = 4;
      send(4'b1111, tt, cc, 64'd0);
      tick(2);
      chk("t5_pre_valid", m_tvalid, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("t5_async_valid", m_tvalid, 0);
      chk("t5_async_sready", s_tready, 0);
      tick(1);
      rst = 1'b1;
      m_tready = 1'b1;
      seen.delete();
      tick(8);
      chk("t5_no_stale", seen.size(), 0);
      chk("t5_idle", m_tvalid, 0);

`ifdef SI_TAG_SERIALIZER_CHANNEL_FILTER_EN
      // channel filter
      do_reset();
      channel_mask = '0;
      channel_mask[2] = 1'b1;
      tt = '0; cc = '0; tt[0] = 7; tt[1] = 8; cc[0] = 6'd3; cc[1] = 6'h3F;
      send(4'b0011, tt, cc, 64'd0);
      tick(1);
      chk("t6_valid", m_tvalid, 1);
      chk("t6_ch", 64'(m_channel[5:0]), 3);
      chk("t6_last", m_tlast, 1);
      tick(1);
      chk("t6_only_one", m_tvalid, 0);
`endif

      // randomized stream
      do_reset();
      rnd_en = 1;
      base = {32'h0, $urandom};
      for (int b = 0; b < 300; b++) begin
         for (int i = 0; i < N; i++) begin
            int c;
            base = base + 64'($urandom_range(0, 50));
            tt[i] = base;
            c = $urandom_range(1, CC);
            cc[i] = $urandom_range(0, 1) ? 6'(c) : 6'(-c);
         end
`ifdef SI_TAG_SERIALIZER_CHANNEL_FILTER_EN
         channel_mask = {$urandom, $urandom};
`endif
         send(4'($urandom_range(0, 15)), tt, cc, base - 64'($urandom_range(0, 100)) + 64'd50);
         tick($urandom_range(0, 2));
      end
      rnd_en = 0;
      tick(1);
      m_tready = 1'b1;
      tick(10);
      chk("drain_empty", q.size(), 0);
      chk("drain_idle", m_tvalid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
